// File: rtl/gpio_ctrl.sv
// gpio_ctrl: memory-mapped GPIO port with per-bit direction, input
// synchroniser, and rising/falling edge interrupts with W1C status.
// Writes are single-cycle on the rising clk edge. Reads are combinational from addr.
module gpio_ctrl #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [4:0]       addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   input  logic [WIDTH-1:0] gpio_in,
   output logic [WIDTH-1:0] gpio_out,
   output logic [WIDTH-1:0] gpio_oe,
   output logic             irq
);

   localparam int CW = $clog2(SYNC_STAGES + 2);
   localparam logic [CW-1:0] WARM_MAX = CW'(SYNC_STAGES + 1);

   localparam logic [2:0] REG_DATA_OUT   = 3'd0;
   localparam logic [2:0] REG_DATA_IN    = 3'd1;
   localparam logic [2:0] REG_DIR        = 3'd2;
   localparam logic [2:0] REG_RISE_EN    = 3'd3;
   localparam logic [2:0] REG_FALL_EN    = 3'd4;
   localparam logic [2:0] REG_IRQ_STATUS = 3'd5;

   logic [WIDTH-1:0] data_out_r;
   logic [WIDTH-1:0] dir_r;
   logic [WIDTH-1:0] rise_en_r;
   logic [WIDTH-1:0] fall_en_r;
   logic [WIDTH-1:0] irq_status_r;
   logic [WIDTH-1:0] sync_r [SYNC_STAGES];
   logic [WIDTH-1:0] prev_r;
   logic [CW-1:0]    warm_cnt_r;

   logic [2:0]       sel_s;
   logic [WIDTH-1:0] wval_s;
   logic [WIDTH-1:0] sync_last_s;
   logic [WIDTH-1:0] rise_s;
   logic [WIDTH-1:0] fall_s;
   logic [WIDTH-1:0] set_s;
   logic [WIDTH-1:0] w1c_s;
   logic [WIDTH-1:0] irq_status_nxt_s;
   logic             armed_s;
   logic [31:0]      rdata_s;
   logic             unused_s;

   assign sel_s       = addr[4:2];
   assign wval_s      = wdata[WIDTH-1:0];
   assign sync_last_s = sync_r[SYNC_STAGES-1];
   assign rise_s      = sync_last_s & ~prev_r;
   assign fall_s      = ~sync_last_s & prev_r;
   assign armed_s     = (warm_cnt_r == WARM_MAX);
   // addr[1:0] and the upper write-data bits carry no meaning here
   assign unused_s    = ^{addr[1:0], wdata};

   // Software-visible control registers written by the CPU
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out_r <= '0;
         dir_r      <= '0;
         rise_en_r  <= '0;
         fall_en_r  <= '0;
      end else if (we) begin
         case (sel_s)
            REG_DATA_OUT: data_out_r <= wval_s;
            REG_DIR:      dir_r      <= wval_s;
            REG_RISE_EN:  rise_en_r  <= wval_s;
            REG_FALL_EN:  fall_en_r  <= wval_s;
            default:      ;
         endcase
      end
   end

   // Input synchroniser chain, edge-detect history and post-reset warm-up counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_r[i] <= '0;
         end
         prev_r     <= '0;
         warm_cnt_r <= '0;
      end else begin
         sync_r[0] <= gpio_in;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
         end
         prev_r <= sync_last_s;
         if (!armed_s) begin
            warm_cnt_r <= warm_cnt_r + CW'(1);
         end
      end
   end

   // Next interrupt status: W1C clears, but a new edge event in the same cycle wins
   always_comb begin
      set_s            = '0;
      w1c_s            = '0;
      irq_status_nxt_s = irq_status_r;
      if (armed_s) begin
         set_s = (rise_s & rise_en_r) | (fall_s & fall_en_r);
      end else begin
         set_s = '0;
      end
      if (we && (sel_s == REG_IRQ_STATUS)) begin
         w1c_s = wval_s;
      end else begin
         w1c_s = '0;
      end
      irq_status_nxt_s = (irq_status_r & ~w1c_s) | set_s;
   end

   // Sticky interrupt status register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_status_r <= '0;
      end else begin
         irq_status_r <= irq_status_nxt_s;
      end
   end

   // Read mux; unmapped addresses and bits above WIDTH read as zero
   always_comb begin
      rdata_s = 32'h0000_0000;
      case (sel_s)
         REG_DATA_OUT:   rdata_s[WIDTH-1:0] = data_out_r;
         REG_DATA_IN:    rdata_s[WIDTH-1:0] = sync_last_s;
         REG_DIR:        rdata_s[WIDTH-1:0] = dir_r;
         REG_RISE_EN:    rdata_s[WIDTH-1:0] = rise_en_r;
         REG_FALL_EN:    rdata_s[WIDTH-1:0] = fall_en_r;
         REG_IRQ_STATUS: rdata_s[WIDTH-1:0] = irq_status_r;
         default:        rdata_s = 32'h0000_0000;
      endcase
   end

   assign rdata    = rdata_s;
   assign gpio_out = data_out_r;
   assign gpio_oe  = dir_r;
   assign irq      = |irq_status_r;

endmodule

// File: tb/tb_gpio_ctrl.sv
// tb_gpio_ctrl: directed table-driven bench for gpio_ctrl (WIDTH=8,
// SYNC_STAGES=2) plus a WIDTH=32 instance for full-width readback.
module tb_gpio_ctrl;

   logic        clk;
   logic        rst_n;
   logic        we;
   logic [4:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [7:0]  gpio_in;
   logic [7:0]  gpio_out;
   logic [7:0]  gpio_oe;
   logic        irq;

   logic [31:0] rdata32;
   logic [31:0] gpio_in32;
   logic [31:0] gpio_out32;
   logic [31:0] gpio_oe32;
   logic        irq32;

   int n_checks;
   int n_errors;

   gpio_ctrl #(.WIDTH(8), .SYNC_STAGES(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata), .gpio_in(gpio_in), .gpio_out(gpio_out),
      .gpio_oe(gpio_oe), .irq(irq)
   );

   gpio_ctrl #(.WIDTH(32), .SYNC_STAGES(2)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata32), .gpio_in(gpio_in32), .gpio_out(gpio_out32),
      .gpio_oe(gpio_oe32), .irq(irq32)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [7:0]  gi;
      logic [31:0] exp_rd;
      logic [7:0]  exp_out;
      logic [7:0]  exp_oe;
      logic        exp_irq;
   } vec_t;

   vec_t vecs [30];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // drive between edges, clock once, sample 1 ns after the rising edge
   task automatic step(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [7:0] g);
      @(negedge clk);
      we = w; addr = a; wdata = d; gpio_in = g;
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input logic w, input logic [4:0] a, input logic [31:0] d,
                               input logic [7:0] g, input logic [31:0] rd, input logic [7:0] o,
                               input logic [7:0] e, input logic i);
      vec_t v;
      v.we = w; v.addr = a; v.wdata = d; v.gi = g;
      v.exp_rd = rd; v.exp_out = o; v.exp_oe = e; v.exp_irq = i;
      return v;
   endfunction

   initial begin
      n_checks = 0;
      n_errors = 0;
      we = 1'b0; addr = 5'h00; wdata = 32'h0; gpio_in = 8'hFF; gpio_in32 = 32'h0;
      rst_n = 1'b0;

      // warm-up + register map + readback
      vecs[0]  = mk(1'b1, 5'h0C, 32'h0000_00FF, 8'hFF, 32'h0000_00FF, 8'h00, 8'h00, 1'b0);
      vecs[1]  = mk(1'b0, 5'h04, 32'h0,         8'hFF, 32'h0000_00FF, 8'h00, 8'h00, 1'b0);
      vecs[2]  = mk(1'b0, 5'h14, 32'h0,         8'hFF, 32'h0000_0000, 8'h00, 8'h00, 1'b0);
      vecs[3]  = mk(1'b0, 5'h14, 32'h0,         8'hFF, 32'h0000_0000, 8'h00, 8'h00, 1'b0);
      vecs[4]  = mk(1'b0, 5'h00, 32'h0,         8'hFF, 32'h0000_0000, 8'h00, 8'h00, 1'b0);
      vecs[5]  = mk(1'b0, 5'h08, 32'h0,         8'hFF, 32'h0000_0000, 8'h00, 8'h00, 1'b0);
      vecs[6]  = mk(1'b0, 5'h10, 32'h0,         8'hFF, 32'h0000_0000, 8'h00, 8'h00, 1'b0);
      vecs[7]  = mk(1'b0, 5'h18, 32'h0,         8'hFF, 32'h0000_0000, 8'h00, 8'h00, 1'b0);
      vecs[8]  = mk(1'b0, 5'h1C, 32'h0,         8'hFF, 32'h0000_0000, 8'h00, 8'h00, 1'b0);
      vecs[9]  = mk(1'b1, 5'h00, 32'hDEAD_BEA5, 8'hFF, 32'h0000_00A5, 8'hA5, 8'h00, 1'b0);
      vecs[10] = mk(1'b1, 5'h08, 32'h0000_000F, 8'hFF, 32'h0000_000F, 8'hA5, 8'h0F, 1'b0);
      vecs[11] = mk(1'b0, 5'h00, 32'h0,         8'hFF, 32'h0000_00A5, 8'hA5, 8'h0F, 1'b0);
      vecs[12] = mk(1'b1, 5'h04, 32'h0,         8'hFF, 32'h0000_00FF, 8'hA5, 8'h0F, 1'b0);
      vecs[13] = mk(1'b1, 5'h1C, 32'hFFFF_FFFF, 8'hFF, 32'h0000_0000, 8'hA5, 8'h0F, 1'b0);
      vecs[14] = mk(1'b0, 5'h08, 32'h0,         8'hFF, 32'h0000_000F, 8'hA5, 8'h0F, 1'b0);
      // falling edge on pin 7, W1C behaviour
      vecs[15] = mk(1'b1, 5'h0C, 32'h0,         8'hFF, 32'h0000_0000, 8'hA5, 8'h0F, 1'b0);
      vecs[16] = mk(1'b1, 5'h10, 32'h0000_0080, 8'hFF, 32'h0000_0080, 8'hA5, 8'h0F, 1'b0);
      vecs[17] = mk(1'b0, 5'h14, 32'h0,         8'h7F, 32'h0000_0000, 8'hA5, 8'h0F, 1'b0);
      vecs[18] = mk(1'b0, 5'h14, 32'h0,         8'h7F, 32'h0000_0000, 8'hA5, 8'h0F, 1'b0);
      vecs[19] = mk(1'b0, 5'h14, 32'h0,         8'h7F, 32'h0000_0080, 8'hA5, 8'h0F, 1'b1);
      vecs[20] = mk(1'b1, 5'h14, 32'h0000_007F, 8'h7F, 32'h0000_0080, 8'hA5, 8'h0F, 1'b1);
      vecs[21] = mk(1'b1, 5'h14, 32'h0000_0080, 8'h7F, 32'h0000_0000, 8'hA5, 8'h0F, 1'b0);
      // input latency: pin 0 rising with RISE_EN=0x01
      vecs[22] = mk(1'b0, 5'h04, 32'h0,         8'hFE, 32'h0000_007F, 8'hA5, 8'h0F, 1'b0);
      vecs[23] = mk(1'b0, 5'h04, 32'h0,         8'hFE, 32'h0000_00FE, 8'hA5, 8'h0F, 1'b0);
      vecs[24] = mk(1'b0, 5'h14, 32'h0,         8'hFE, 32'h0000_0000, 8'hA5, 8'h0F, 1'b0);
      vecs[25] = mk(1'b1, 5'h0C, 32'h0000_0001, 8'hFE, 32'h0000_0001, 8'hA5, 8'h0F, 1'b0);
      vecs[26] = mk(1'b0, 5'h04, 32'h0,         8'hFF, 32'h0000_00FE, 8'hA5, 8'h0F, 1'b0);
      vecs[27] = mk(1'b0, 5'h04, 32'h0,         8'hFF, 32'h0000_00FF, 8'hA5, 8'h0F, 1'b0);
      vecs[28] = mk(1'b0, 5'h14, 32'h0,         8'hFF, 32'h0000_0001, 8'hA5, 8'h0F, 1'b1);
      vecs[29] = mk(1'b1, 5'h14, 32'h0000_0001, 8'hFF, 32'h0000_0000, 8'hA5, 8'h0F, 1'b0);

      // reset state, with pins held high through reset
      repeat (3) @(posedge clk);
      #1;
      check("reset_gpio_out", {24'h0, gpio_out}, 32'h0);
      check("reset_gpio_oe", {24'h0, gpio_oe}, 32'h0);
      check("reset_irq", {31'h0, irq}, 32'h0);
      addr = 5'h04;
      #1;
      check("reset_data_in", rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 30; i++) begin
         step(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].gi);
         check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
         check($sformatf("vec%0d_gpio_out", i), {24'h0, gpio_out}, {24'h0, vecs[i].exp_out});
         check($sformatf("vec%0d_gpio_oe", i), {24'h0, gpio_oe}, {24'h0, vecs[i].exp_oe});
         check($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
      end

      // collision: W1C of bit 3 on the same edge its rising event sets it
      step(1'b1, 5'h0C, 32'h0000_0008, 8'hFF);
      repeat (3) step(1'b0, 5'h14, 32'h0, 8'hF7);
      check("coll_pre_status", rdata, 32'h0);
      step(1'b0, 5'h14, 32'h0, 8'hFF);
      step(1'b0, 5'h14, 32'h0, 8'hFF);
      check("coll_before_set", rdata, 32'h0);
      step(1'b1, 5'h14, 32'h0000_0008, 8'hFF);
      check("coll_status", rdata, 32'h0000_0008);
      check("coll_irq", {31'h0, irq}, 32'h1);
      step(1'b1, 5'h14, 32'h0000_0008, 8'hFF);
      check("coll_cleared", rdata, 32'h0);

      // reset mid-operation with pending status 0x05 and DATA_OUT=0x3C
      step(1'b1, 5'h10, 32'h0000_0005, 8'hFF);
      repeat (3) step(1'b0, 5'h14, 32'h0, 8'hFA);
      check("mid_status", rdata, 32'h0000_0005);
      step(1'b1, 5'h00, 32'h0000_003C, 8'hFA);
      check("mid_data_out", {24'h0, gpio_out}, 32'h0000_003C);
      we = 1'b0;
      addr = 5'h14;
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_gpio_out", {24'h0, gpio_out}, 32'h0);
      check("mid_rst_gpio_oe", {24'h0, gpio_oe}, 32'h0);
      check("mid_rst_irq", {31'h0, irq}, 32'h0);
      check("mid_rst_status", rdata, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 5'h0C, 32'h0000_00FF, 8'hFA);
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 5'h14, 32'h0, 8'hFA);
         check($sformatf("warm_status%0d", i), rdata, 32'h0);
         check($sformatf("warm_irq%0d", i), {31'h0, irq}, 32'h0);
      end
      step(1'b0, 5'h04, 32'h0, 8'hFA);
      check("warm_data_in", rdata, 32'h0000_00FA);

      // full-width readback on the 32-bit instance; upper bits dropped on the 8-bit one
      step(1'b1, 5'h00, 32'hFFFF_FFFF, 8'hFA);
      check("w32_rdata_out", rdata32, 32'hFFFF_FFFF);
      check("w32_gpio_out", gpio_out32, 32'hFFFF_FFFF);
      check("w8_rdata_out", rdata, 32'h0000_00FF);
      step(1'b1, 5'h08, 32'hFFFF_FFFF, 8'hFA);
      check("w32_rdata_dir", rdata32, 32'hFFFF_FFFF);
      check("w32_gpio_oe", gpio_oe32, 32'hFFFF_FFFF);
      step(1'b0, 5'h1C, 32'h0, 8'hFA);
      check("w32_unmapped", rdata32, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
